// File: rtl/cp0_ctrl.sv
// cp0_ctrl - MIPS-style coprocessor-0 controller.
//
// Holds the exception/interrupt state for a simple MIPS core: BadVAddr(8),
// Count(9), Compare(11), Status(12), Cause(13) and EPC(14). It also produces the
// interrupt request, and registers the fetch redirect for exceptions and eret.
//
// Build option: define CP0_TIMER_EN to include the Count/Compare timer.
// Without it, Count and Compare read 0, writes to them are ignored, and TI
// stays 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_addr, i_sel     register number / select (only sel 0 is implemented)
//   i_din, i_cp0_write  software write data / strobe
//   o_dout            combinational read data
//   i_hw_irq          level-sensitive hardware interrupt lines
//   i_exc_req, i_exc_code, i_exc_pc, i_exc_bd, i_exc_badvaddr  exception entry
//   i_eret            exception return
//   o_irq_pending     interrupt request to the pipeline
//   o_exc_redirect, o_redirect_pc  one-cycle redirect strobe and target
//   o_epc             current EPC
module cp0_ctrl #(
    parameter int          HW_IRQ_N   = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          i_addr,
    input  logic [2:0]          i_sel,
    input  logic [31:0]         i_din,
    input  logic                i_cp0_write,
    output logic [31:0]         o_dout,
    input  logic [HW_IRQ_N-1:0] i_hw_irq,
    input  logic                i_exc_req,
    input  logic [4:0]          i_exc_code,
    input  logic [31:0]         i_exc_pc,
    input  logic                i_exc_bd,
    input  logic [31:0]         i_exc_badvaddr,
    input  logic                i_eret,
    output logic                o_irq_pending,
    output logic                o_exc_redirect,
    output logic [31:0]         o_redirect_pc,
    output logic [31:0]         o_epc
);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_hw_irq;
    logic        r_exc_redirect;
    logic [31:0] r_redirect_pc;

    logic [5:0]  w_hw_pad;
    logic [7:0]  w_ip;
    logic        w_sw_wr;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;

    // Software writes lose to any exception or eret in the same cycle.
    assign w_sw_wr = i_cp0_write & ~i_exc_req & ~i_eret & (i_sel == 3'd0);

    // Widen the interrupt lines to six so that unused IP bits stay zero.
    always_comb begin
        w_hw_pad = '0;
        w_hw_pad[HW_IRQ_N-1:0] = i_hw_irq;
    end

    // IP[15] is shared between hw_irq[5] and the timer interrupt.
    assign w_ip = {r_hw_irq[5] | w_ti, r_hw_irq[4:0], r_ip_sw};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr     <= '0;
            r_epc          <= '0;
            r_im           <= '0;
            r_exl          <= 1'b0;
            r_ie           <= 1'b0;
            r_bd           <= 1'b0;
            r_exccode      <= '0;
            r_ip_sw        <= '0;
            r_hw_irq       <= '0;
            r_exc_redirect <= 1'b0;
            r_redirect_pc  <= '0;
        end else begin
            r_hw_irq       <= w_hw_pad;
            r_exc_redirect <= 1'b0;
            r_redirect_pc  <= '0;
            if (i_exc_req) begin
                // A nested exception keeps the original return point.
                if (!r_exl) begin
                    r_epc <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
                    r_bd  <= i_exc_bd;
                end
                r_exccode <= i_exc_code;
                r_exl     <= 1'b1;
                // Only address-error exceptions (AdEL/AdES) latch BadVAddr.
                if (i_exc_code == 5'd4 || i_exc_code == 5'd5)
                    r_badvaddr <= i_exc_badvaddr;
                r_exc_redirect <= 1'b1;
                r_redirect_pc  <= EXC_VECTOR;
            end else if (i_eret) begin
                r_exl          <= 1'b0;
                r_exc_redirect <= 1'b1;
                r_redirect_pc  <= r_epc;
            end else if (w_sw_wr) begin
                case (i_addr)
                    A_STATUS: begin
                        r_im  <= i_din[15:8];
                        r_exl <= i_din[1];
                        r_ie  <= i_din[0];
                    end
                    A_CAUSE: r_ip_sw <= i_din[9:8];
                    A_EPC:   r_epc   <= i_din;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_ti;
    logic          w_wr_count;
    logic          w_wr_compare;
    logic          w_presc_tc;
    logic          w_count_chg;
    logic [31:0]   w_count_next;

    assign w_wr_count   = w_sw_wr & (i_addr == A_COUNT);
    assign w_wr_compare = w_sw_wr & (i_addr == A_COMPARE);
    assign w_presc_tc   = (r_presc == PW'(COUNT_DIV - 1));

    always_comb begin
        w_count_next = r_count;
        w_count_chg  = 1'b0;
        if (w_wr_count) begin
            w_count_next = i_din;
            w_count_chg  = 1'b1;
        end else if (w_presc_tc) begin
            w_count_next = r_count + 32'd1;
            w_count_chg  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_presc <= (w_wr_count || w_presc_tc) ? '0 : r_presc + 1'b1;
            if (w_wr_compare)
                r_compare <= i_din;
            // A Compare write wins over a match in the same cycle.
            if (w_wr_compare)
                r_ti <= 1'b0;
            else if (w_count_chg && (w_count_next == r_compare))
                r_ti <= 1'b1;
        end
    end

    assign w_count   = r_count;
    assign w_compare = r_compare;
    assign w_ti      = r_ti;
`else
    assign w_count   = '0;
    assign w_compare = '0;
    assign w_ti      = 1'b0;
`endif

    always_comb begin
        o_dout = '0;
        if (i_sel == 3'd0) begin
            case (i_addr)
                A_BADVADDR: o_dout = r_badvaddr;
                A_COUNT:    o_dout = w_count;
                A_COMPARE:  o_dout = w_compare;
                A_STATUS:   o_dout = {16'h0, r_im, 6'h0, r_exl, r_ie};
                A_CAUSE:    o_dout = {r_bd, w_ti, 14'h0, w_ip, 1'b0, r_exccode, 2'b00};
                A_EPC:      o_dout = r_epc;
                default:    o_dout = '0;
            endcase
        end
    end

    assign o_irq_pending  = r_ie & ~r_exl & (|(w_ip & r_im));
    assign o_exc_redirect = r_exc_redirect;
    assign o_redirect_pc  = r_redirect_pc;
    assign o_epc          = r_epc;

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Parameter HW_IRQ_N, default 6, number of hardware interrupt lines (legal 1..6).
REQ-002 Parameter EXC_VECTOR, default 32'hBFC0_0380, exception entry PC.
REQ-003 Parameter COUNT_DIV, default 2, clk cycles per Count increment (legal >=1).
REQ-004 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-005 Ports: clk in 1 clock; rst in 1 sync reset.
REQ-006 Ports: addr in 5 reg number; sel in 3 select; din in 32 write data; cp0_write in 1 write enable; dout out 32 read data.
REQ-007 Ports: hw_irq in HW_IRQ_N level interrupts; exc_req in 1 take exception; exc_code in 5 ExcCode; exc_pc in 32 faulting PC; exc_bd in 1 faulting instr in delay slot; exc_badvaddr in 32 bad address.
REQ-008 Ports: eret in 1 return; irq_pending out 1 interrupt request; exc_redirect out 1 redirect strobe; redirect_pc out 32 target; epc out 32 EPC.

Function
REQ-009 Implemented regs SHALL be BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); all other addr, or sel!=0, read 32'h0 and ignore writes.
REQ-010 dout SHALL be combinational from current register state; a read in the write cycle returns the old value.
REQ-011 Status writable bits SHALL be IM[15:8], EXL[1], IE[0]; other bits read 0.
REQ-012 Cause SHALL hold BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] are software-writable; other bits read 0.
REQ-013 Cause.IP[10+k] SHALL equal hw_irq[k] registered each cycle for k<HW_IRQ_N; IP[15] SHALL be (hw_irq[5] if present) OR TI; unused IP bits read 0.
REQ-014 BadVAddr SHALL be read-only to software; EPC fully writable.
REQ-015 irq_pending SHALL equal Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), combinational.
REQ-016 On exc_req at posedge with EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc; BD <= exc_bd.
REQ-017 On exc_req with EXL=1: EPC and BD SHALL be unchanged.
REQ-018 On any exc_req: ExcCode <= exc_code, EXL <= 1; BadVAddr <= exc_badvaddr only when exc_code is 4 or 5.
REQ-019 On eret (no exc_req): EXL <= 0.
REQ-020 Priority: exc_req > eret > cp0_write; a cp0_write in the same cycle as exc_req or eret SHALL be discarded.
REQ-021 exc_redirect SHALL pulse high exactly one cycle after an accepted exc_req or eret; redirect_pc = EXC_VECTOR for exceptions, EPC value (post-update) for eret; redirect_pc = 0 when not redirecting.
REQ-022 epc SHALL always present the current EPC register.
REQ-023 Count SHALL increment by 1 every COUNT_DIV cycles via a prescaler, wrapping 32'hFFFF_FFFF -> 0.
REQ-024 Writing Count SHALL load din and clear the prescaler; that cycle does not increment.
REQ-025 TI SHALL set on the cycle Count becomes equal to Compare through increment or write, and stay set until Compare is written (write clears TI; a simultaneous match does not re-set it).

Reset
REQ-026 On rst all registers, prescaler, TI, exc_redirect and redirect_pc SHALL be 0; irq_pending therefore 0.
REQ-027 rst SHALL dominate exc_req, eret and cp0_write in the same cycle; a pending redirect is cancelled.

Configuration
REQ-028 Macro CP0_TIMER_EN defined: Count/Compare/TI behave per REQ-023..025.
REQ-029 Macro CP0_TIMER_EN undefined: Count and Compare read 0, writes ignored, no prescaler logic, TI constantly 0.

Verification
REQ-030 Reset, then read addr 12,13,14 -> dout 0; irq_pending 0; exc_redirect 0.
REQ-031 Write Status=32'h0000_0401, pulse hw_irq[0] -> irq_pending 1 one cycle later; set EXL via exc_req -> irq_pending 0.
REQ-032 exc_req, exc_pc=32'h8000_0104, exc_bd=1, exc_code=4, badvaddr=32'h1234_5679 -> EPC 32'h8000_0100, BD 1, BadVAddr 32'h1234_5679, next cycle exc_redirect=1, redirect_pc=32'hBFC0_0380.
REQ-033 Second exc_req while EXL=1 with exc_pc=32'h8000_0200 -> EPC stays 32'h8000_0100, ExcCode updated; eret -> EXL 0, redirect_pc 32'h8000_0100.
REQ-034 Timer (CP0_TIMER_EN, COUNT_DIV=2): Count=32'hFFFF_FFFF, Compare=1 -> Count wraps to 0 after 2 cycles, TI=1 after 4; write Compare -> TI 0.
REQ-035 cp0_write to Status coincident with exc_req -> write discarded, EXL=1, IE unchanged.
